min_reduce_ctrl: RTL and testbench
==================================

# min_reduce_ctrl

Sequencer that reduces a packet of floating-point values to its minimum and the index of that minimum. It time-shares one `min` datapath instance, running in half or single precision, by feeding back the running minimum. It sits between a valid/ready element stream and a valid/ready result consumer. It handles the datapath's multi-cycle latency, detects a stalled datapath, and flushes stale results after reset or timeout.

## Interface
Parameters:
- BITS, 16, element width; 16 for HALF, 32 for SINGLE
- PRECISION, "HALF", passed to the `min` instance ("HALF" or "SINGLE")
- IDX_BITS, 10, index width; max packet length is 2^IDX_BITS
- MAX_WAIT, 32, cycles to wait for `out_valid`; also the flush length; must exceed datapath latency

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_valid  in  1  input element valid
- s_ready  out  1  input element accepted when s_valid & s_ready
- s_data  in  BITS  element value
- s_last  in  1  marks the final element of a packet
- m_valid  out  1  result valid; held until m_ready
- m_ready  in  1  result consumer ready
- m_min  out  BITS  minimum value of the packet
- m_index  out  IDX_BITS  zero-based position of the minimum
- m_count  out  IDX_BITS+1  number of elements consumed
- m_status  out  2  bit0 = timeout, bit1 = truncated
- busy  out  1  high in any state other than IDLE

## Operation
- States: FLUSH, IDLE, ACCEPT, WAIT, DONE.
- Reset:
  - State enters FLUSH with wait counter 0.
  - All registers clear: cur_min, cur_idx, cnt, pend_idx, pend_last, status.
  - Outputs during reset: s_ready=0, m_valid=0, m_min=0, m_index=0, m_count=0, m_status=0, busy=1.
- FLUSH:
  - s_ready=0.
  - Counts MAX_WAIT cycles, then goes to IDLE.
  - Exists because the `min` pipeline is not reset; it drains any in-flight result.
- IDLE: s_ready=1. On handshake:
  - cur_min=s_data, cur_idx=0, cnt=1, status=0.
  - s_last=1 goes to DONE; otherwise goes to ACCEPT.
- ACCEPT: s_ready=1. On handshake:
  - Pulse `min` in_valid for exactly one cycle, with a=cur_min and b=s_data.
  - pend_idx=cnt, cnt=cnt+1, pend_last=s_last, wait counter cleared.
  - Go to WAIT.
- Forced last: if the accepted element's index equals 2^IDX_BITS-1 and s_last=0:
  - Treat it as last and set status bit1.
  - Following elements start a new packet.
- WAIT: s_ready=0. On `min` out_valid:
  - cur_min=c.
  - If b_min=1, cur_idx=pend_idx.
  - pend_last=1 goes to DONE; otherwise goes to ACCEPT.
- WAIT timeout: if out_valid is absent for MAX_WAIT cycles:
  - Set status bit0.
  - cur_min and cur_idx stay unchanged; the pending element is excluded from the result.
  - Go to DONE.
- Tie handling: `min` asserts b_min only when b < a strictly, so ties keep the earliest index.
- DONE:
  - m_valid=1; m_min=cur_min, m_index=cur_idx, m_count=cnt, m_status=status, all stable.
  - On m_ready, go to FLUSH if status bit0 is set, otherwise IDLE.
- out_valid arriving in any state other than WAIT is ignored.
- Reset asserted in any state aborts the packet immediately; no result is emitted.

## Timing
- Only the ACCEPT handshake cycle drives `min` in_valid. At most one operation is in flight.
- Throughput: the first element costs 1 cycle; each later element costs 1 + L cycles, where L is the `min` latency.
- Result timing:
  - Single-element packet: handshake at cycle t gives m_valid=1 at t+1.
  - Otherwise: out_valid of the last element at t gives m_valid=1 at t+1.
- Timeout: in_valid at t with no out_valid gives m_valid=1 at t+MAX_WAIT+1.
- Back-to-back packets: s_ready=1 in the cycle after the m_valid & m_ready handshake, unless a flush follows.
- FLUSH length: s_ready returns to 1 exactly MAX_WAIT cycles after entering FLUSH.

## Test plan
- HALF packet 0x4200, 0x3C00, 0x4000, 0xC000(last) -> m_min=0xC000, m_index=3, m_count=4, m_status=0; each non-first element shows s_ready low for L cycles.
- Ties, packet 0x4000, 0x3C00, 0x3C00(last) -> m_min=0x3C00, m_index=1, m_count=3.
- Single element 0x5140(last) -> m_valid one cycle later, m_min=0x5140, m_index=0, m_count=1; hold m_ready=0 for 5 cycles -> outputs stable, s_ready=0.
- Stub datapath that never asserts out_valid, packet 0x4000, 0x3C00(last) -> m_status=01, m_min=0x4000, m_count=2, m_valid at t+MAX_WAIT+1; after m_ready, s_ready stays 0 for MAX_WAIT cycles.
- IDX_BITS=2, six elements with only the sixth marked last -> first result m_count=4, m_status=10; second result m_count=2, m_status=00.
- Deassert rstn during WAIT, inject a stale out_valid 3 cycles after release -> stale result ignored, no m_valid; the next packet 0x3C00, 0x4000(last) gives m_min=0x3C00, m_index=0.

Source files
------------

// File: rtl/min_reduce_ctrl.sv
// Packet minimum/argmin sequencer built around one time-shared floating-point min unit.
`timescale 1ns/1ps

// Pipelined floating-point minimum; b_min flags b < a strictly. The pipeline has no reset.
module fp_min #(
    parameter int unsigned BITS      = 16,
    parameter string       PRECISION = "HALF",
    parameter int unsigned LATENCY   = 2
) (
    input  logic            clk,
    input  logic            in_valid,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    output logic [BITS-1:0] c,
    output logic            b_min
);
    localparam int unsigned EXP_W = (PRECISION == "SINGLE") ? 8 : 5;
    localparam int unsigned MAN_W = BITS - 1 - EXP_W;

    logic            a_nan_c, b_nan_c, both_zero_c, b_lt_a_c;
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] bmin_q;
    logic [BITS-1:0]    c_q [LATENCY];

    assign a_nan_c     = (&a[BITS-2 -: EXP_W]) & (|a[MAN_W-1:0]);
    assign b_nan_c     = (&b[BITS-2 -: EXP_W]) & (|b[MAN_W-1:0]);
    assign both_zero_c = ~(|a[BITS-2:0]) & ~(|b[BITS-2:0]);

    // Sign-magnitude ordering; unordered operands and +0/-0 never select b.
    always_comb begin
        b_lt_a_c = 1'b0;
        if (!a_nan_c && !b_nan_c && !both_zero_c) begin
            unique case ({a[BITS-1], b[BITS-1]})
                2'b00:   b_lt_a_c = (b[BITS-2:0] < a[BITS-2:0]);
                2'b11:   b_lt_a_c = (b[BITS-2:0] > a[BITS-2:0]);
                2'b01:   b_lt_a_c = 1'b1;
                default: b_lt_a_c = 1'b0;
            endcase
        end
    end

    // Fixed-latency delay line for the result.
    always_ff @(posedge clk) begin
        vld_q[0]  <= in_valid;
        bmin_q[0] <= b_lt_a_c;
        c_q[0]    <= b_lt_a_c ? b : a;
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_q[i]  <= vld_q[i-1];
            bmin_q[i] <= bmin_q[i-1];
            c_q[i]    <= c_q[i-1];
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign b_min     = bmin_q[LATENCY-1];
    assign c         = c_q[LATENCY-1];
endmodule

module min_reduce_ctrl #(
    parameter int unsigned BITS        = 16,
    parameter string       PRECISION   = "HALF",
    parameter int unsigned IDX_BITS    = 10,
    parameter int unsigned MAX_WAIT    = 32,
    parameter int unsigned MIN_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BITS-1:0]     s_data,
    input  logic                s_last,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BITS-1:0]     m_min,
    output logic [IDX_BITS-1:0] m_index,
    output logic [IDX_BITS:0]   m_count,
    output logic [1:0]          m_status,
    output logic                busy
);
    localparam int unsigned CNT_W  = IDX_BITS + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'((1 << IDX_BITS) - 1);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_ACCEPT,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [BITS-1:0]     cur_min_q, cur_min_d;
    logic [IDX_BITS-1:0] cur_idx_q, cur_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_BITS-1:0] pend_idx_q, pend_idx_d;
    logic                pend_last_q, pend_last_d;
    logic [1:0]          status_q, status_d;
    logic                s_ready_q, s_ready_d;
    logic                m_valid_q, m_valid_d;
    logic                busy_q, busy_d;

    logic                mn_in_valid_c;
    logic                mn_out_valid;
    logic [BITS-1:0]     mn_c;
    logic                mn_b_min;

    fp_min #(
        .BITS      (BITS),
        .PRECISION (PRECISION),
        .LATENCY   (MIN_LATENCY)
    ) u_min (
        .clk       (clk),
        .in_valid  (mn_in_valid_c),
        .a         (cur_min_q),
        .b         (s_data),
        .out_valid (mn_out_valid),
        .c         (mn_c),
        .b_min     (mn_b_min)
    );

    // Next-state and datapath-issue logic; outputs follow the next state.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        cur_min_d     = cur_min_q;
        cur_idx_d     = cur_idx_q;
        cnt_d         = cnt_q;
        pend_idx_d    = pend_idx_q;
        pend_last_d   = pend_last_q;
        status_d      = status_q;
        mn_in_valid_c = 1'b0;

        unique case (state_q)
            ST_FLUSH: begin
                if (wait_q == WAIT_END) begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_IDLE: begin
                if (s_valid) begin
                    cur_min_d = s_data;
                    cur_idx_d = '0;
                    cnt_d     = CNT_W'(1);
                    status_d  = '0;
                    state_d   = s_last ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (s_valid) begin
                    mn_in_valid_c = 1'b1;
                    pend_idx_d    = cnt_q[IDX_BITS-1:0];
                    cnt_d         = cnt_q + CNT_W'(1);
                    pend_last_d   = s_last;
                    wait_d        = '0;
                    // Highest representable index closes the packet early.
                    if (!s_last && cnt_q == LAST_IDX) begin
                        pend_last_d = 1'b1;
                        status_d[1] = 1'b1;
                    end
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mn_out_valid) begin
                    cur_min_d = mn_c;
                    if (mn_b_min) begin
                        cur_idx_d = pend_idx_q;
                    end
                    state_d = pend_last_q ? ST_DONE : ST_ACCEPT;
                end else if (wait_q == WAIT_END) begin
                    status_d[0] = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DONE: begin
                if (m_ready) begin
                    if (status_q[0]) begin
                        state_d = ST_FLUSH;
                        wait_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_FLUSH;
                wait_d  = '0;
            end
        endcase

        s_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCEPT);
        m_valid_d = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and result registers; reset lands in FLUSH to drain the unreset datapath.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_FLUSH;
            wait_q      <= '0;
            cur_min_q   <= '0;
            cur_idx_q   <= '0;
            cnt_q       <= '0;
            pend_idx_q  <= '0;
            pend_last_q <= 1'b0;
            status_q    <= '0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cur_min_q   <= cur_min_d;
            cur_idx_q   <= cur_idx_d;
            cnt_q       <= cnt_d;
            pend_idx_q  <= pend_idx_d;
            pend_last_q <= pend_last_d;
            status_q    <= status_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign busy     = busy_q;
    assign m_min    = cur_min_q;
    assign m_index  = cur_idx_q;
    assign m_count  = cnt_q;
    assign m_status = status_q;
endmodule

// File: tb/tb_min_reduce_ctrl.sv
// Randomized bench for min_reduce_ctrl with a real-valued packet reference model.
`timescale 1ns/1ps

module tb_min_reduce_ctrl;
    localparam int unsigned BITS     = 16;
    localparam int unsigned IDX_BITS = 2;
    localparam int unsigned MAX_WAIT = 8;
    localparam int unsigned LAT      = 2;
    localparam int          MAX_LEN  = 1 << IDX_BITS;

    typedef struct packed {
        logic [15:0] mn;
        logic [1:0]  idx;
        logic [2:0]  cnt;
        logic [1:0]  st;
    } res_t;

    logic                clk = 1'b0;
    logic                rstn = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [BITS-1:0]     s_data = '0;
    logic                s_last = 1'b0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [BITS-1:0]     m_min;
    logic [IDX_BITS-1:0] m_index;
    logic [IDX_BITS:0]   m_count;
    logic [1:0]          m_status;
    logic                busy;

    int   checks = 0;
    int   failures = 0;
    bit   hold_ready = 1'b0;
    res_t exp_q[$];

    min_reduce_ctrl #(
        .BITS        (BITS),
        .PRECISION   ("HALF"),
        .IDX_BITS    (IDX_BITS),
        .MAX_WAIT    (MAX_WAIT),
        .MIN_LATENCY (LAT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_min    (m_min),
        .m_index  (m_index),
        .m_count  (m_count),
        .m_status (m_status),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic real half_val(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) m = real'(h[9:0]) * (2.0 ** (-24));
        else        m = real'({1'b1, h[9:0]}) * (2.0 ** (e - 25));
        return h[15] ? -m : m;
    endfunction

    // Splits a packet at the index limit and computes min/first-argmin per result.
    task automatic model_packet(input logic [15:0] vals[$]);
        int   base;
        int   len;
        bit   trunc;
        res_t r;
        base = 0;
        while (base < vals.size()) begin
            len   = vals.size() - base;
            trunc = 1'b0;
            if (len > MAX_LEN) begin
                len   = MAX_LEN;
                trunc = 1'b1;
            end
            r.mn  = vals[base];
            r.idx = '0;
            for (int i = 1; i < len; i++) begin
                if (half_val(vals[base + i]) < half_val(r.mn)) begin
                    r.mn  = vals[base + i];
                    r.idx = 2'(i);
                end
            end
            r.cnt = 3'(len);
            r.st  = {trunc, 1'b0};
            exp_q.push_back(r);
            base += len;
        end
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] pool [8];
        logic [15:0] h;
        pool = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h4000, 16'hC000, 16'h0001, 16'h7BFF};
        if ($urandom_range(0, 1) == 0) begin
            h = pool[$urandom_range(0, 7)];
        end else begin
            h = 16'($urandom);
            if (h[14:10] == 5'h1F) h[14] = 1'b0;
        end
        return h;
    endfunction

    // Called at posedge+1; returns after the handshake edge, reporting cycles stalled.
    task automatic send_elem(input logic [15:0] d, input logic l, output int waited);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) check_eq("s_ready_wait", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        waited  = n;
    endtask

    task automatic send_packet(input logic [15:0] vals[$], input bit gaps);
        int w;
        model_packet(vals);
        foreach (vals[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_elem(vals[i], (i == vals.size() - 1), w);
        end
    endtask

    task automatic cycles_to_ready(output int n);
        n = 0;
        while (!s_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_s_ready"},  32'(s_ready),  32'd0);
        check_eq({tag, "_m_valid"},  32'(m_valid),  32'd0);
        check_eq({tag, "_m_min"},    32'(m_min),    32'd0);
        check_eq({tag, "_m_index"},  32'(m_index),  32'd0);
        check_eq({tag, "_m_count"},  32'(m_count),  32'd0);
        check_eq({tag, "_m_status"}, 32'(m_status), 32'd0);
        check_eq({tag, "_busy"},     32'(busy),     32'd1);
    endtask

    // Result consumer: random backpressure, scoreboard compare on each handshake.
    initial begin
        res_t r;
        forever begin
            @(posedge clk); #1;
            m_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (rstn && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    check_eq("m_min",    32'(m_min),    32'(r.mn));
                    check_eq("m_index",  32'(m_index),  32'(r.idx));
                    check_eq("m_count",  32'(m_count),  32'(r.cnt));
                    check_eq("m_status", 32'(m_status), 32'(r.st));
                end
            end
        end
    end

    initial begin
        logic [15:0] vals[$];
        int w;
        int n;
        int len;

        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        rstn = 1'b1;
        cycles_to_ready(n);
        check_eq("flush_len_por", 32'(n), 32'(MAX_WAIT));

        // Mixed-sign packet; each later element stalls for the datapath latency.
        vals = '{16'h4200, 16'h3C00, 16'h4000, 16'hC000};
        model_packet(vals);
        foreach (vals[i]) begin
            send_elem(vals[i], (i == 3), w);
            if (i >= 2) check_eq($sformatf("stall_elem%0d", i), 32'(w), 32'(LAT));
        end

        // Ties keep the earliest index.
        vals = '{16'h4000, 16'h3C00, 16'h3C00};
        send_packet(vals, 1'b0);

        // Single element with the consumer stalled.
        cycles_to_ready(n);
        hold_ready = 1'b1;
        vals = '{16'h5140};
        model_packet(vals);
        send_elem(16'h5140, 1'b1, w);
        check_eq("single_latency", 32'(m_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("hold_m_valid", 32'(m_valid), 32'd1);
            check_eq("hold_m_min",   32'(m_min),   32'h5140);
            check_eq("hold_s_ready", 32'(s_ready), 32'd0);
        end
        hold_ready = 1'b0;

        // Datapath that never answers.
        cycles_to_ready(n);
        force dut.mn_out_valid = 1'b0;
        hold_ready = 1'b1;
        exp_q.push_back('{mn: 16'h4000, idx: 2'd0, cnt: 3'd2, st: 2'b01});
        send_elem(16'h4000, 1'b0, w);
        send_elem(16'h3C00, 1'b1, w);
        n = 0;
        while (!m_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("timeout_latency", 32'(n), 32'(MAX_WAIT));
        check_eq("timeout_status", 32'(m_status), 32'd1);
        release dut.mn_out_valid;
        hold_ready = 1'b0;
        n = 0;
        while (m_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        cycles_to_ready(n);
        check_eq("flush_len_timeout", 32'(n), 32'(MAX_WAIT));

        // Six elements, only the last marked: splits at the index limit.
        vals = '{16'h4400, 16'h4200, 16'h4000, 16'h3C00, 16'h3800, 16'h4600};
        send_packet(vals, 1'b0);

        // Reset while an operation is in flight, then a stale out_valid during flush.
        cycles_to_ready(n);
        send_elem(16'h4000, 1'b0, w);
        send_elem(16'h3C00, 1'b0, w);
        rstn = 1'b0;
        #1;
        reset_checks("mid_wait");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        n = 0;
        while (!s_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) force dut.mn_out_valid = 1'b1;
            if (n == 4) release dut.mn_out_valid;
            if (m_valid) check_eq("stale_m_valid", 32'(m_valid), 32'd0);
        end
        check_eq("flush_len_rst", 32'(n), 32'(MAX_WAIT));
        vals = '{16'h3C00, 16'h4000};
        send_packet(vals, 1'b0);

        // Random packets, including lengths past the index limit.
        for (int p = 0; p < 40; p++) begin
            vals.delete();
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) vals.push_back(rand_half());
            send_packet(vals, 1'b1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("results_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
